// File: rtl/trigger_pulse_sequencer.sv
// rtl/trigger_pulse_sequencer.sv - arms on command, skips N triggers, launches the delay unit, emits a pulse train
module trigger_pulse_sequencer #(
  parameter int DELAY_BITS = 32,
  parameter int SKIP_BITS  = 16,
  parameter int PULSE_BITS = 16,
  parameter int COUNT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DELAY_BITS-1:0] cfg_delay,
  input  logic [SKIP_BITS-1:0]  cfg_skip,
  input  logic [COUNT_BITS-1:0] cfg_pulse_count,
  input  logic [PULSE_BITS-1:0] cfg_pulse_width,
  input  logic [PULSE_BITS-1:0] cfg_pulse_gap,
  input  logic                  cfg_rearm,
  input  logic                  trig_pulse,
  output logic [DELAY_BITS-1:0] dly_cycles,
  output logic                  dly_update,
  output logic                  dly_trigger,
  input  logic                  dly_done,
  output logic                  pulse_out,
  output logic                  armed,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [SKIP_BITS-1:0]  trig_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARMED, S_WAIT_DLY, S_PULSE_HI, S_PULSE_LO, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [SKIP_BITS-1:0]  skip_q, skip_cnt_q, skip_cnt_d;
  logic [COUNT_BITS-1:0] count_q, pulse_cnt_q, pulse_cnt_d;
  logic [PULSE_BITS-1:0] width_q, gap_q, phase_cnt_q, phase_cnt_d;
  logic                  rearm_q;
  logic [SKIP_BITS-1:0]  trig_count_q, trig_count_d;
  logic                  overrun_q, overrun_d;
  logic                  latch_cfg;
  logic [DELAY_BITS-1:0] dly_cycles_q, dly_cycles_d;
  logic                  dly_update_q, dly_update_d;
  logic                  dly_trigger_q, dly_trigger_d;
  logic                  pulse_out_q, pulse_out_d;
  logic                  armed_q, armed_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      skip_q        <= '0;
      count_q       <= '0;
      width_q       <= '0;
      gap_q         <= '0;
      rearm_q       <= 1'b0;
      skip_cnt_q    <= '0;
      pulse_cnt_q   <= '0;
      phase_cnt_q   <= '0;
      trig_count_q  <= '0;
      overrun_q     <= 1'b0;
      dly_cycles_q  <= '0;
      dly_update_q  <= 1'b0;
      dly_trigger_q <= 1'b0;
      pulse_out_q   <= 1'b0;
      armed_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      pulse_cnt_q   <= pulse_cnt_d;
      phase_cnt_q   <= phase_cnt_d;
      trig_count_q  <= trig_count_d;
      overrun_q     <= overrun_d;
      dly_cycles_q  <= dly_cycles_d;
      dly_update_q  <= dly_update_d;
      dly_trigger_q <= dly_trigger_d;
      pulse_out_q   <= pulse_out_d;
      armed_q       <= armed_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      // Zero-valued count/width/gap are clamped once here so the counters never see 0.
      if (latch_cfg) begin
        skip_q  <= cfg_skip;
        count_q <= (cfg_pulse_count == '0) ? COUNT_BITS'(1) : cfg_pulse_count;
        width_q <= (cfg_pulse_width == '0) ? PULSE_BITS'(1) : cfg_pulse_width;
        gap_q   <= (cfg_pulse_gap == '0) ? PULSE_BITS'(1) : cfg_pulse_gap;
        rearm_q <= cfg_rearm;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    pulse_cnt_d  = pulse_cnt_q;
    phase_cnt_d  = phase_cnt_q;
    trig_count_d = trig_count_q;
    overrun_d    = overrun_q;
    latch_cfg    = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (arm) begin
          state_d      = S_LOAD;
          latch_cfg    = 1'b1;
          overrun_d    = 1'b0;
          trig_count_d = '0;
          skip_cnt_d   = '0;
        end
        S_LOAD: state_d = S_ARMED;
        S_ARMED: if (trig_pulse) begin
          if (trig_count_q != '1) trig_count_d = trig_count_q + 1'b1;
          if (skip_cnt_q < skip_q) skip_cnt_d = skip_cnt_q + 1'b1;
          else state_d = S_WAIT_DLY;
        end
        S_WAIT_DLY: begin
          if (trig_pulse) overrun_d = 1'b1;
          if (dly_done) begin
            state_d     = S_PULSE_HI;
            phase_cnt_d = width_q - 1'b1;
            pulse_cnt_d = count_q;
          end
        end
        S_PULSE_HI: begin
          if (trig_pulse) overrun_d = 1'b1;
          if (phase_cnt_q == '0) begin
            pulse_cnt_d = pulse_cnt_q - 1'b1;
            if (pulse_cnt_q == COUNT_BITS'(1)) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_PULSE_LO;
              phase_cnt_d = gap_q - 1'b1;
            end
          end else begin
            phase_cnt_d = phase_cnt_q - 1'b1;
          end
        end
        S_PULSE_LO: begin
          if (trig_pulse) overrun_d = 1'b1;
          if (phase_cnt_q == '0) begin
            state_d     = S_PULSE_HI;
            phase_cnt_d = width_q - 1'b1;
          end else begin
            phase_cnt_d = phase_cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          if (rearm_q) begin
            state_d    = S_ARMED;
            skip_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they appear in the cycle the state is entered.
  always_comb begin
    pulse_out_d   = (state_d == S_PULSE_HI);
    armed_d       = (state_d == S_ARMED);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    dly_update_d  = (state_d == S_LOAD);
    dly_trigger_d = (state_q == S_ARMED) && (state_d == S_WAIT_DLY);
    dly_cycles_d  = latch_cfg ? cfg_delay : dly_cycles_q;
  end

  assign dly_cycles  = dly_cycles_q;
  assign dly_update  = dly_update_q;
  assign dly_trigger = dly_trigger_q;
  assign pulse_out   = pulse_out_q;
  assign armed       = armed_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign trig_count  = trig_count_q;

endmodule

// File: tb/tb_trigger_pulse_sequencer.sv
// tb/tb_trigger_pulse_sequencer.sv - directed and randomized checks of trigger_pulse_sequencer
module tb_trigger_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_delay = '0;
  logic [15:0] cfg_skip = '0;
  logic [7:0]  cfg_pulse_count = '0;
  logic [15:0] cfg_pulse_width = '0;
  logic [15:0] cfg_pulse_gap = '0;
  logic        cfg_rearm = 1'b0;
  logic        trig_pulse = 1'b0;
  logic        dly_done = 1'b0;
  logic [31:0] dly_cycles;
  logic        dly_update, dly_trigger, pulse_out, armed, busy, done, overrun;
  logic [15:0] trig_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trigger_pulse_sequencer #(
    .DELAY_BITS(32), .SKIP_BITS(16), .PULSE_BITS(16), .COUNT_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .cfg_delay(cfg_delay), .cfg_skip(cfg_skip), .cfg_pulse_count(cfg_pulse_count),
    .cfg_pulse_width(cfg_pulse_width), .cfg_pulse_gap(cfg_pulse_gap), .cfg_rearm(cfg_rearm),
    .trig_pulse(trig_pulse), .dly_cycles(dly_cycles), .dly_update(dly_update),
    .dly_trigger(dly_trigger), .dly_done(dly_done), .pulse_out(pulse_out),
    .armed(armed), .busy(busy), .done(done), .overrun(overrun), .trig_count(trig_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Offset k counts cycles from the first high cycle of the train.
  function automatic logic model_pulse(input int k, input int c, input int w, input int g);
    if (k >= c * w + (c - 1) * g) return 1'b0;
    return ((k % (w + g)) < w);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cycles"}, dly_cycles, 0);
    chk({tag, "_outs"}, {dly_update, dly_trigger, pulse_out, armed, busy, done, overrun}, 0);
    chk({tag, "_tcount"}, trig_count, 0);
  endtask

  // Arms from IDLE, then scrambles cfg to show the shadow copy is what gets used.
  task automatic do_arm(input logic [31:0] d, input int s, input int c, input int w,
                        input int g, input logic r);
    cfg_delay = d; cfg_skip = 16'(s); cfg_pulse_count = 8'(c);
    cfg_pulse_width = 16'(w); cfg_pulse_gap = 16'(g); cfg_rearm = r;
    arm = 1'b1;
    step();
    arm = 1'b0;
    cfg_delay = $urandom; cfg_skip = 16'($urandom); cfg_pulse_count = 8'($urandom);
    cfg_pulse_width = 16'($urandom); cfg_pulse_gap = 16'($urandom); cfg_rearm = ~r;
    chk("load_update", dly_update, 1);
    chk("load_cycles", dly_cycles, d);
    chk("load_busy", busy, 1);
    step();
    chk("armed", armed, 1);
    chk("armed_update_off", dly_update, 0);
  endtask

  task automatic fire_trig(input int exp_count);
    trig_pulse = 1'b1;
    step();
    trig_pulse = 1'b0;
    chk("fire_trigger", dly_trigger, 1);
    chk("fire_tcount", trig_count, exp_count);
    chk("fire_update", dly_update, 0);
    step();
    chk("fire_trigger_once", dly_trigger, 0);
  endtask

  // Returns dly_done and checks the full train up to and including the DONE cycle.
  task automatic run_train(input int c, input int w, input int g, input int trig_at);
    int t;
    t = c * w + (c - 1) * g;
    dly_done = 1'b1;
    step();
    dly_done = 1'b0;
    for (int k = 0; k <= t; k++) begin
      chk($sformatf("train_pulse_k%0d", k), pulse_out, model_pulse(k, c, w, g));
      chk($sformatf("train_done_k%0d", k), done, (k == t));
      if (k < t) begin
        trig_pulse = (k == trig_at);
        step();
        trig_pulse = 1'b0;
      end
    end
  endtask

  initial begin
    int s, c, w, g, spacing, wait_n;
    logic inject, exp_ov;

    step();
    step();
    chk_all_zero("reset");
    rst = 1'b1;

    // Basic fire
    do_arm(32'd10, 0, 1, 3, 1, 1'b0);
    fire_trig(1);
    repeat (8) step();
    run_train(1, 3, 1, -1);
    step();
    chk("basic_idle_busy", busy, 0);
    chk("basic_idle_done", done, 0);

    // Skip two triggers
    do_arm(32'd4, 2, 1, 1, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      trig_pulse = 1'b1;
      step();
      trig_pulse = 1'b0;
      chk("skip_trigger", dly_trigger, (i == 2));
      chk("skip_tcount", trig_count, i + 1);
      if (i < 2) repeat (4) step();
    end
    run_train(1, 1, 1, -1);
    step();
    chk("skip_idle", busy, 0);

    // Pulse train, then zero clamping
    do_arm(32'd3, 0, 3, 2, 4, 1'b0);
    fire_trig(1);
    run_train(3, 2, 4, -1);
    step();
    do_arm(32'd3, 0, 0, 0, 0, 1'b0);
    fire_trig(1);
    run_train(1, 1, 1, -1);
    step();
    chk("clamp_idle", busy, 0);

    // Rearm and overrun
    do_arm(32'd20, 0, 2, 3, 2, 1'b1);
    fire_trig(1);
    repeat (3) step();
    run_train(2, 3, 2, 1);
    step();
    chk("rearm_armed", armed, 1);
    chk("rearm_overrun", overrun, 1);
    chk("rearm_tcount", trig_count, 1);
    chk("rearm_no_update", dly_update, 0);
    fire_trig(2);
    run_train(2, 3, 2, -1);
    step();
    chk("rearm2_armed", armed, 1);
    chk("rearm2_tcount", trig_count, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("rearm_abort_busy", busy, 0);
    chk("rearm_abort_cycles", dly_cycles, 20);

    // Abort beats dly_done in WAIT_DLY
    do_arm(32'd5, 0, 1, 4, 1, 1'b0);
    fire_trig(1);
    step();
    abort = 1'b1;
    dly_done = 1'b1;
    step();
    abort = 1'b0;
    dly_done = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cycles_held", dly_cycles, 5);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_pulse", {pulse_out, done}, 0);
      step();
    end

    // Abort during PULSE_HI
    do_arm(32'd5, 0, 1, 4, 1, 1'b0);
    fire_trig(1);
    dly_done = 1'b1;
    step();
    dly_done = 1'b0;
    chk("abort_hi_pulse", pulse_out, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_hi_drop", {pulse_out, busy, done}, 0);

    // Reset in PULSE_LO
    do_arm(32'd9, 0, 2, 2, 5, 1'b0);
    fire_trig(1);
    trig_pulse = 1'b1;
    step();
    trig_pulse = 1'b0;
    chk("wait_overrun", overrun, 1);
    chk("wait_tcount", trig_count, 1);
    dly_done = 1'b1;
    step();
    dly_done = 1'b0;
    repeat (3) step();
    chk("mid_lo", pulse_out, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_all_zero("midreset");
    do_arm(32'd7, 0, 1, 1, 1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Randomized sequences against the reference model
    for (int it = 0; it < 16; it++) begin
      s = $urandom_range(0, 3);
      c = $urandom_range(0, 4);
      w = $urandom_range(0, 4);
      g = $urandom_range(0, 4);
      do_arm($urandom, s, c, w, g, 1'b0);
      for (int i = 0; i <= s; i++) begin
        spacing = $urandom_range(0, 3);
        for (int j = 0; j < spacing; j++) begin
          step();
          chk("rnd_idle_trigger", dly_trigger, 0);
        end
        trig_pulse = 1'b1;
        step();
        trig_pulse = 1'b0;
        chk("rnd_trigger", dly_trigger, (i == s));
        chk("rnd_tcount", trig_count, i + 1);
      end
      inject = 1'($urandom_range(0, 1));
      wait_n = $urandom_range(0, 5);
      exp_ov = inject && (wait_n > 0);
      for (int j = 0; j < wait_n; j++) begin
        trig_pulse = inject && (j == 0);
        step();
        trig_pulse = 1'b0;
      end
      run_train(eff(c), eff(w), eff(g), -1);
      chk("rnd_overrun", overrun, exp_ov);
      chk("rnd_tcount_final", trig_count, s + 1);
      step();
      chk("rnd_idle", {busy, done, pulse_out}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trigger_pulse_sequencer.md
Name: trigger_pulse_sequencer

Overview:
Control block that sequences the trigger delay datapath. It loads and holds the delay value, arms on command, and skips a programmable number of qualified trigger edges. On the selected edge it launches the delay unit, then emits a programmable train of output pulses when the delayed trigger returns. It sits between the register/host interface and the edge-detect plus configurable-delay pipeline.

Parameters:
DELAY_BITS, 32, width of the delay value passed to the delay unit
SKIP_BITS, 16, width of the trigger-skip counter and the trig_count status
PULSE_BITS, 16, width of the pulse width and pulse gap counters
COUNT_BITS, 8, width of the pulse-count field

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-low reset
arm  in  1  1-cycle request to latch the configuration and arm the block
abort  in  1  1-cycle request to return to IDLE from any state
cfg_delay  in  DELAY_BITS  delay value, in clk cycles
cfg_skip  in  SKIP_BITS  number of qualified triggers to ignore before firing
cfg_pulse_count  in  COUNT_BITS  number of output pulses; 0 is treated as 1
cfg_pulse_width  in  PULSE_BITS  high time per pulse in cycles; 0 is treated as 1
cfg_pulse_gap  in  PULSE_BITS  low time between pulses in cycles; 0 is treated as 1
cfg_rearm  in  1  1 = re-arm automatically after DONE; 0 = go to IDLE
trig_pulse  in  1  synchronized 1-cycle qualified edge from the edge detector
dly_cycles  out  DELAY_BITS  delay value driven to the delay unit
dly_update  out  1  1-cycle load strobe to the delay unit
dly_trigger  out  1  1-cycle launch pulse into the delay unit
dly_done  in  1  delayed trigger pulse returned by the delay unit
pulse_out  out  1  output pulse train, registered
armed  out  1  high in the ARMED state
busy  out  1  high in every state except IDLE
done  out  1  1-cycle strobe when a sequence completes
overrun  out  1  sticky flag: a trig_pulse arrived in WAIT_DLY, PULSE_HI or PULSE_LO; cleared on arm
trig_count  out  SKIP_BITS  number of triggers seen since the block armed; saturates at all-ones

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0, including dly_cycles, trig_count and overrun.
  - All internal counters are cleared.
- States: IDLE, LOAD, ARMED, WAIT_DLY, PULSE_HI, PULSE_LO, DONE.
- All outputs are registered: a state entered at edge t shows its outputs in cycle t.
- IDLE:
  - arm=1 moves to LOAD.
  - In the same edge, cfg_* are latched into shadow registers, overrun and trig_count are cleared, and the skip counter is cleared.
  - cfg_* changes after this point have no effect until the next arm.
  - arm outside IDLE is ignored.
- LOAD:
  - dly_cycles takes the latched delay and dly_update=1 for exactly one cycle.
  - Next state is ARMED.
- ARMED, on trig_pulse:
  - trig_count increments (saturating).
  - If skip_cnt < skip, skip_cnt increments and the state stays ARMED.
  - Otherwise dly_trigger=1 for one cycle and the state moves to WAIT_DLY.
  - With skip=0, the first trigger fires.
- WAIT_DLY:
  - dly_done=1 moves to PULSE_HI, with the width counter loaded and the pulse counter set to the effective pulse count.
  - No timeout; abort is the only other exit.
- PULSE_HI:
  - pulse_out=1 for exactly the effective width in cycles.
  - At the end of the high phase the pulse counter decrements.
  - If it reaches 0, go to DONE; otherwise go to PULSE_LO.
- PULSE_LO:
  - pulse_out=0 for exactly the effective gap in cycles, then go back to PULSE_HI.
- Latency: dly_done sampled high at edge t gives pulse_out high from cycle t+1.
- DONE:
  - done=1 for one cycle and pulse_out=0.
  - If cfg_rearm is latched as 1, go to ARMED: skip_cnt is cleared, trig_count is kept, and the delay is not reloaded.
  - Otherwise go to IDLE.
- trig_pulse in WAIT_DLY, PULSE_HI or PULSE_LO sets overrun and is otherwise ignored: no queueing and no count.
- trig_pulse in IDLE, LOAD or DONE is ignored and does not set overrun.
- abort=1 in any state:
  - State goes to IDLE at the next edge, and pulse_out, dly_trigger and armed drop in that cycle.
  - done is not asserted.
  - dly_cycles is held.
  - abort has priority over arm, trig_pulse and dly_done in the same cycle.
- dly_done outside WAIT_DLY is ignored.
- Reset asserted mid-sequence behaves exactly like power-on reset. The block does not reset the delay unit; the top level shares rst.

Test Plan:
- Basic fire: delay=10, skip=0, count=1, width=3, gap=1, rearm=0; arm, then trig_pulse; return dly_done 10 cycles after dly_trigger -> dly_update once in LOAD, dly_trigger 1 cycle after the trigger, pulse_out high for 3 cycles starting 1 cycle after dly_done, done 1 cycle later, then IDLE with busy=0.
- Skip: skip=2; 3 trig_pulses spaced 5 cycles apart -> dly_trigger only after the 3rd, trig_count=3.
- Train and zero clamping: count=3, width=2, gap=4 -> pulse_out pattern 11 0000 11 0000 11 then done. Repeat with count=0, width=0, gap=0 -> a single 1-cycle pulse.
- Rearm and overrun: rearm=1; trig_pulse during PULSE_HI -> overrun=1 with no second sequence; after done the block is ARMED again; the next trig fires without a new dly_update; trig_count=2.
- Abort priority: abort and dly_done in the same cycle in WAIT_DLY -> IDLE, pulse_out never rises, no done. Abort during PULSE_HI -> pulse_out low the next cycle.
- Reset mid-train: rst=0 for 1 cycle during PULSE_LO -> all outputs 0 and IDLE. A following arm with new cfg_delay=7 -> dly_cycles=7.
